kamikaze_fetch: RTL and testbench

- Instruction-fetch/prefetch stage between the kamikaze core's decode stage and the synchronous-read instruction memory (1-cycle read latency, always ready).
- Generates word-aligned fetch addresses, tracks the in-flight read, and buffers returned words with their PCs in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Supports a redirect (branch/jump/trap) that flushes all buffered and in-flight fetches.

---
 rtl/kamikaze_pkg.sv | 14 +
 rtl/kamikaze_fetch_if.sv | 24 ++
 rtl/kamikaze_fifo.sv | 55 +++++
 rtl/kamikaze_fetch.sv | 77 +++++++
 tb/tb_kamikaze_fetch.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/kamikaze_pkg.sv
// Shared types and constants for the kamikaze core.
package kamikaze_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/kamikaze_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and decode handshake.
interface kamikaze_fetch_if;
    import kamikaze_pkg::*;

    logic [XLEN-1:0] im_addr_o;
    logic [ILEN-1:0] im_data_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            inst_valid_o;
    logic [ILEN-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_ready_i;

    modport master (
        output im_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  im_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  im_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output im_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/kamikaze_fifo.sv
// Registered-output FIFO with occupancy count and synchronous flush.
module kamikaze_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign count_o = count;
    assign rdata_o = mem[rptr];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/kamikaze_fetch.sv
// Instruction fetch/prefetch: credit-based address generation into a small prefetch FIFO.
module kamikaze_fetch
    import kamikaze_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic              clk_i,
    input  logic              rst_i,
    kamikaze_fetch_if.master  bus
);

    localparam int CW     = $clog2(DEPTH+1);
    localparam int DATA_W = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc;
    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic            issue, push, pop;
    logic [CW:0]     credit;
    logic [CW-1:0]   count;
    logic            full, empty;
    fetch_entry_t    wentry, head;

    // Slots already claimed (buffered + in flight) after this cycle's pop.
    assign pop    = !empty && bus.inst_ready_i;
    assign credit = (CW+1)'(count) + (CW+1)'(vld_p1) - (CW+1)'(pop);
    assign issue  = !bus.redirect_i && (credit < (CW+1)'(DEPTH));
    assign push   = vld_p1 && !bus.redirect_i;

    // Stage p0: address presented to memory
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i & ~32'h3;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) pc_p1 <= fetch_pc;
    end

    // Stage p1: memory data returns and is written into the FIFO
    assign wentry.pc   = pc_p1;
    assign wentry.inst = bus.im_data_i;

    kamikaze_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.redirect_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.im_addr_o    = fetch_pc;
    assign bus.inst_valid_o = !empty;
    assign bus.inst_o       = empty ? '0 : head.inst;
    assign bus.inst_pc_o    = empty ? '0 : head.pc;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(push && full && !pop));

endmodule

// File: tb/tb_kamikaze_fetch.sv
// Scoreboard bench for kamikaze_fetch: expected PC stream queued per redirect/reset.
module tb_kamikaze_fetch;
    import kamikaze_pkg::*;

    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    kamikaze_fetch_if bus ();

    kamikaze_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous-read instruction memory, one cycle latency
    always_ff @(posedge clk_i) bus.im_data_i <= mem_word(bus.im_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_stream(input logic [31:0] p);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(p + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd0);
        check({tag, "_addr"},  bus.im_addr_o, 32'd0);
        check({tag, "_inst"},  bus.inst_o, 32'd0);
        check({tag, "_pc"},    bus.inst_pc_o, 32'd0);
    endtask

    // Monitor: pops compared against the expected stream, stability under backpressure
    initial begin
        logic        pv;
        logic        pr;
        logic [31:0] pinst, ppc, e;
        pv = 1'b0;
        pr = 1'b0;
        pinst = '0;
        ppc = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                pv = 1'b0;
            end else begin
                check("addr_align", {30'b0, bus.im_addr_o[1:0]}, 32'd0);
                check("occ_max", 32'(dut.u_fifo.count_o <= 3'(DEPTH)), 32'd1);
                if (pv && !pr) begin
                    check("hold_valid", 32'(bus.inst_valid_o), 32'd1);
                    check("hold_pc", bus.inst_pc_o, ppc);
                    check("hold_inst", bus.inst_o, pinst);
                end
                if (bus.inst_valid_o && bus.inst_ready_i) begin
                    e = exp_q.pop_front();
                    exp_q.push_back(exp_q[$] + 32'd4);
                    check("deliv_pc", bus.inst_pc_o, e);
                    check("deliv_inst", bus.inst_o, mem_word(e));
                end
                if (bus.redirect_i) begin
                    load_stream(bus.redirect_pc_i & ~32'h3);
                    pv = 1'b0;
                end else begin
                    pv = bus.inst_valid_o;
                    pr = bus.inst_ready_i;
                    pinst = bus.inst_o;
                    ppc = bus.inst_pc_o;
                end
            end
        end
    end

    initial begin
        rst_i = 1'b0;
        bus.inst_ready_i  = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        load_stream(32'h0);
        #2;
        check_reset_outputs("rst0");

        // Test 1: latency and streaming after reset release
        tick();
        tick();
        rst_i = 1'b1;
        check("t1_addr0", bus.im_addr_o, 32'h0);
        tick();
        check("t1_addr1", bus.im_addr_o, 32'h4);
        check("t1_valid1", 32'(bus.inst_valid_o), 32'd0);
        tick();
        check("t1_addr2", bus.im_addr_o, 32'h8);
        check("t1_valid2", 32'(bus.inst_valid_o), 32'd1);
        check("t1_pc_first", bus.inst_pc_o, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_stream_valid", 32'(bus.inst_valid_o), 32'd1);
        end

        // Test 2: fill under backpressure, then drain
        rst_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        load_stream(32'h0);
        tick();
        tick();
        rst_i = 1'b1;
        repeat (8) tick();
        check("t2_addr_stall", bus.im_addr_o, 32'h10);
        check("t2_valid", 32'(bus.inst_valid_o), 32'd1);
        check("t2_head_pc", bus.inst_pc_o, 32'h0);
        check("t2_head_inst", bus.inst_o, mem_word(32'h0));
        check("t2_occ", 32'(dut.u_fifo.count_o), 32'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_addr_hold", bus.im_addr_o, 32'h10);
        end
        bus.inst_ready_i = 1'b1;
        repeat (12) tick();

        // Test 3: redirect with 3 buffered entries and one in flight
        rst_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        load_stream(32'h0);
        tick();
        rst_i = 1'b1;
        repeat (4) tick();
        check("t3_occ", 32'(dut.u_fifo.count_o), 32'd3);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        tick();
        bus.redirect_i   = 1'b0;
        bus.inst_ready_i = 1'b1;
        check("t3_valid_flush", 32'(bus.inst_valid_o), 32'd0);
        check("t3_addr", bus.im_addr_o, 32'h100);
        tick();
        tick();
        check("t3_valid", 32'(bus.inst_valid_o), 32'd1);
        check("t3_pc", bus.inst_pc_o, 32'h100);
        repeat (4) tick();

        // Test 4: redirect coinciding with a pop, second redirect next cycle
        check("t4_pre_valid", 32'(bus.inst_valid_o), 32'd1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0300;
        tick();
        check("t4_valid_flush", 32'(bus.inst_valid_o), 32'd0);
        bus.redirect_pc_i = 32'h0000_0200;
        tick();
        bus.redirect_i = 1'b0;
        check("t4_addr", bus.im_addr_o, 32'h200);
        tick();
        tick();
        check("t4_pc", bus.inst_pc_o, 32'h200);
        repeat (4) tick();

        // Test 5: PC wrap at the top of the address space
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        bus.redirect_i = 1'b0;
        tick();
        tick();
        check("t5_pc0", bus.inst_pc_o, 32'hFFFF_FFF8);
        tick();
        check("t5_pc1", bus.inst_pc_o, 32'hFFFF_FFFC);
        tick();
        check("t5_pc2", bus.inst_pc_o, 32'h0000_0000);
        tick();
        check("t5_pc3", bus.inst_pc_o, 32'h0000_0004);

        // Test 6: random backpressure with an asynchronous reset mid-stream
        for (int i = 0; i < 1000; i++) begin
            bus.inst_ready_i = 1'($urandom_range(0, 1));
            if (i == 600) begin
                #2;
                rst_i = 1'b0;
                #1;
                check_reset_outputs("t6_rst");
                load_stream(32'h0);
                tick();
                tick();
                rst_i = 1'b1;
            end
            tick();
        end
        bus.inst_ready_i = 1'b1;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
